ct_butterfly_pipe: RTL and testbench



---
 rtl/ct_butterfly_if.sv | 50 +++++
 rtl/ct_butterfly_pipe.sv | 176 +++++++++++++++++
 tb/tb_ct_butterfly_pipe.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ct_butterfly_if.sv
// ---------------------------------------------------------------------------
// ct_butterfly_if
//  Bundle of the data/handshake signals of the NTT butterfly pipeline.
//  master : upstream (delay-alignment stage / bench) drives operands, receives results
//  slave  : the butterfly pipeline itself
//  Signals:
//   en         pipeline advance (0 = whole pipeline holds)
//   in_valid   a/b/w/in_tag valid this cycle
//   a, b, w    operands and twiddle, data_width bits, each < Q
//   in_tag     write-address tag, TAG_W bits
//   bypass     (only with BFLY_BYPASS_EN) copy pass: u=a, v=b
//   out_valid  u/v/out_tag valid
//   u, v       (a+b*w) mod Q, (a-b*w) mod Q
//   out_tag    in_tag delayed to line up with u/v
//  Optional feature macro: BFLY_BYPASS_EN
// ---------------------------------------------------------------------------
interface ct_butterfly_if #(
  parameter int data_width = 24,
  parameter int TAG_W      = 8
);
  logic                  en;
  logic                  in_valid;
  logic [data_width-1:0] a;
  logic [data_width-1:0] b;
  logic [data_width-1:0] w;
  logic [TAG_W-1:0]      in_tag;
`ifdef BFLY_BYPASS_EN
  logic                  bypass;
`endif
  logic                  out_valid;
  logic [data_width-1:0] u;
  logic [data_width-1:0] v;
  logic [TAG_W-1:0]      out_tag;

  modport master (
`ifdef BFLY_BYPASS_EN
    output bypass,
`endif
    output en, in_valid, a, b, w, in_tag,
    input  out_valid, u, v, out_tag
  );

  modport slave (
`ifdef BFLY_BYPASS_EN
    input  bypass,
`endif
    input  en, in_valid, a, b, w, in_tag,
    output out_valid, u, v, out_tag
  );
endinterface

// File: rtl/ct_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// ct_butterfly_pipe
//  Six-stage pipelined Cooley-Tukey NTT butterfly:
//    u = (a + b*w) mod Q,  v = (a - b*w) mod Q
//  The modular product uses Barrett reduction with BM = floor(2^(2*data_width)/Q).
//  A valid bit and a write-address tag travel in lock-step with the data so the
//  writeback side needs no separate delay line. One butterfly per cycle; en=0
//  freezes every register (inputs are ignored in that cycle).
//  Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears every pipeline register
//   bus    ct_butterfly_if.slave (en, in_valid, a, b, w, in_tag [, bypass],
//          out_valid, u, v, out_tag)
//  Optional feature macro: BFLY_BYPASS_EN adds bus.bypass; a sample with
//  bypass=1 yields u=a, v=b with the same latency, valid and tag behaviour.
//  Stages:
//   S1 register inputs | S2 p=b*w | S3 Barrett quotient t | S4 r=p-t*Q (<3Q)
//   S5 m=r mod Q       | S6 u/v add/sub with single correction
// ---------------------------------------------------------------------------
module ct_butterfly_pipe #(
  parameter int          data_width = 24,
  parameter int unsigned Q          = 8380417,
  parameter int          TAG_W      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  ct_butterfly_if.slave  bus
);
  localparam int DW  = data_width;
  localparam int PW2 = 2 * DW;
  localparam longint unsigned BM64 = (64'd1 << PW2) / 64'(Q);
  localparam int BM_W = $clog2(BM64 + 64'd1);
  // Width of p*BM; everything below bit PW2 is discarded by the shift.
  localparam int PW  = PW2 + BM_W;
  // t <= p/Q < Q, so DW+1 bits are ample.
  localparam int TW  = DW + 1;
  // r < 3Q < 2^(DW+1); DW+2 bits keep the subtraction unambiguous.
  localparam int RW  = DW + 2;

  localparam logic [BM_W-1:0] BM  = BM_W'(BM64);
  localparam logic [DW-1:0]   QD  = DW'(Q);
  localparam logic [TW-1:0]   QT  = TW'(Q);
  localparam logic [RW-1:0]   QR  = RW'(Q);
  localparam logic [RW-1:0]   Q2R = RW'(2 * Q);

  // Side-band lock-step shift registers (index = stage number)
  logic [6:1]        valid_pipe;
  logic [TAG_W-1:0]  tag_pipe [1:6];
  // Upper operand delayed S1..S5 so it meets m at S6
  logic [DW-1:0]     a_pipe   [1:5];

  // Arithmetic stage registers
  logic [DW-1:0]     b1_reg;
  logic [DW-1:0]     w1_reg;
  logic [PW2-1:0]    p2_reg;
  logic [PW2-1:0]    p3_reg;
  logic [TW-1:0]     t3_reg;
  logic [RW-1:0]     r4_reg;
  logic [DW-1:0]     m5_reg;
  logic [DW-1:0]     u6_reg;
  logic [DW-1:0]     v6_reg;

`ifdef BFLY_BYPASS_EN
  logic [5:1]        byp_pipe;
  logic [DW-1:0]     bq_pipe  [2:5];
`endif

  // Combinational next-state values
  logic [PW2-1:0]    p_next;
  logic [TW-1:0]     t_next;
  logic [RW-1:0]     r_next;
  logic [DW-1:0]     m_next;
  logic [DW:0]       sum_w;
  logic [DW-1:0]     u_next;
  logic [DW-1:0]     v_next;

  always_comb begin
    p_next = PW2'(b1_reg) * PW2'(w1_reg);

    // Barrett quotient estimate: floor(p*BM / 2^PW2), underestimates by at most 2.
    t_next = TW'((PW'(p2_reg) * PW'(BM)) >> PW2);

    // Only the low RW bits of p - t*Q matter because the true value is < 3Q.
    r_next = RW'(p3_reg) - (RW'(t3_reg) * QR);

    if (r4_reg >= Q2R) begin
      m_next = DW'(r4_reg - Q2R);
    end else if (r4_reg >= QR) begin
      m_next = DW'(r4_reg - QR);
    end else begin
      m_next = DW'(r4_reg);
    end

    sum_w = {1'b0, a_pipe[5]} + {1'b0, m5_reg};
    if (sum_w >= QT) begin
      u_next = DW'(sum_w - QT);
    end else begin
      u_next = DW'(sum_w);
    end

    // a + (Q - m) stays below Q when a < m, so no wrap is possible.
    if (a_pipe[5] >= m5_reg) begin
      v_next = a_pipe[5] - m5_reg;
    end else begin
      v_next = a_pipe[5] + (QD - m5_reg);
    end

`ifdef BFLY_BYPASS_EN
    if (byp_pipe[5]) begin
      u_next = a_pipe[5];
      v_next = bq_pipe[5];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe <= '0;
      for (int i = 1; i <= 6; i++) begin
        tag_pipe[i] <= '0;
      end
      for (int i = 1; i <= 5; i++) begin
        a_pipe[i] <= '0;
      end
      b1_reg <= '0;
      w1_reg <= '0;
      p2_reg <= '0;
      p3_reg <= '0;
      t3_reg <= '0;
      r4_reg <= '0;
      m5_reg <= '0;
      u6_reg <= '0;
      v6_reg <= '0;
`ifdef BFLY_BYPASS_EN
      byp_pipe <= '0;
      for (int i = 2; i <= 5; i++) begin
        bq_pipe[i] <= '0;
      end
`endif
    end else if (bus.en) begin
      // S1
      valid_pipe  <= {valid_pipe[5:1], bus.in_valid};
      tag_pipe[1] <= bus.in_tag;
      a_pipe[1]   <= bus.a;
      b1_reg      <= bus.b;
      w1_reg      <= bus.w;
      for (int i = 2; i <= 6; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
      for (int i = 2; i <= 5; i++) begin
        a_pipe[i] <= a_pipe[i-1];
      end
      // S2..S6
      p2_reg <= p_next;
      p3_reg <= p2_reg;
      t3_reg <= t_next;
      r4_reg <= r_next;
      m5_reg <= m_next;
      u6_reg <= u_next;
      v6_reg <= v_next;
`ifdef BFLY_BYPASS_EN
      byp_pipe   <= {byp_pipe[4:1], bus.bypass};
      bq_pipe[2] <= b1_reg;
      for (int i = 3; i <= 5; i++) begin
        bq_pipe[i] <= bq_pipe[i-1];
      end
`endif
    end
  end

  assign bus.out_valid = valid_pipe[6];
  assign bus.out_tag   = tag_pipe[6];
  assign bus.u         = u6_reg;
  assign bus.v         = v6_reg;

endmodule

// File: tb/tb_ct_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// tb_ct_butterfly_pipe
//  Scoreboard bench for ct_butterfly_pipe. Stimulus pushes the expected
//  {u, v, tag, due en-cycle} for each valid sample; a negedge monitor pops and
//  compares whenever out_valid is presented after an advancing edge, checks
//  that results arrive on exactly the expected en-cycle, and that outputs hold
//  while en=0. Define BFLY_BYPASS_EN to include the bypass vectors.
// ---------------------------------------------------------------------------
module tb_ct_butterfly_pipe;
  localparam int DW = 24;
  localparam int TW = 8;
  localparam int unsigned Q = 8380417;

  typedef struct {
    logic [DW-1:0] u;
    logic [DW-1:0] v;
    logic [TW-1:0] tag;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ct_butterfly_if #(.data_width(DW), .TAG_W(TW)) bus ();

  ct_butterfly_pipe #(.data_width(DW), .Q(Q), .TAG_W(TW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ecount = 0;
  bit   en_q = 1'b0;
  logic [DW-1:0] last_u = '0;
  logic [DW-1:0] last_v = '0;
  logic [TW-1:0] last_tag = '0;
  logic          last_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent modular reference (no Barrett)
  function automatic void ref_bfly(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] w,
                                   output logic [DW-1:0] u, output logic [DW-1:0] v);
    longint unsigned p;
    p = (longint'(b) * longint'(w)) % Q;
    u = DW'((longint'(a) + p) % Q);
    v = DW'((longint'(a) + Q - p) % Q);
  endfunction

  // Advance-edge counter and the en value seen at that edge
  always @(posedge clk) begin
    en_q <= bus.en;
    if (bus.en) ecount <= ecount + 1;
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (en_q) begin
        if (bus.out_valid) begin
          if (sbq.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("u", bus.u, e.u);
            chk("v", bus.v, e.v);
            chk("tag", bus.out_tag, e.tag);
            chk("latency", ecount, e.due);
            $display("txn tag=%0d u=%0d v=%0d cyc=%0d", bus.out_tag, bus.u, bus.v, ecount);
          end
        end else if (sbq.size() != 0 && sbq[0].due <= ecount) begin
          chk("missing_out", ecount, sbq[0].due + 1000);
          void'(sbq.pop_front());
        end
      end else begin
        chk("hold_valid", bus.out_valid, last_valid);
        chk("hold_u", bus.u, last_u);
        chk("hold_v", bus.v, last_v);
        chk("hold_tag", bus.out_tag, last_tag);
      end
    end
    last_valid = bus.out_valid;
    last_u     = bus.u;
    last_v     = bus.v;
    last_tag   = bus.out_tag;
  end

  // One advancing cycle; valid samples queue their expected result.
  task automatic send(input bit vld, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] w, input logic [TW-1:0] tag, input bit byp,
                      input logic [DW-1:0] eu, input logic [DW-1:0] ev);
    exp_t e;
    bus.en = 1'b1;
    bus.in_valid = vld;
    bus.a = a;
    bus.b = b;
    bus.w = w;
    bus.in_tag = tag;
`ifdef BFLY_BYPASS_EN
    bus.bypass = byp;
`else
    if (byp) $display("note: bypass vector issued without bypass build");
`endif
    if (vld) begin
      e.u = eu;
      e.v = ev;
      e.tag = tag;
      e.due = ecount + 6;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] w, input logic [TW-1:0] tag);
    logic [DW-1:0] eu, ev;
    ref_bfly(a, b, w, eu, ev);
    send(1'b1, a, b, w, tag, 1'b0, eu, ev);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  // en=0 with a live-looking input that must not be captured
  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      bus.en = 1'b0;
      bus.in_valid = 1'b1;
      bus.a = 24'd11;
      bus.b = 24'd22;
      bus.w = 24'd33;
      bus.in_tag = 8'hEE;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.en = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.w = '0;
    bus.in_tag = '0;
`ifdef BFLY_BYPASS_EN
    bus.bypass = 1'b0;
`endif
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_u", bus.u, 0);
    chk("rst_v", bus.v, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T1 / T2 and extra directed vectors (hand-computed)
    send(1'b1, 24'd1, 24'd2, 24'd3, 8'h01, 1'b0, 24'd7, 24'd8380412);
    idle(7);
    send(1'b1, 24'd0, 24'd8380416, 24'd8380416, 8'h02, 1'b0, 24'd1, 24'd8380416);
    send(1'b1, 24'd8380416, 24'd1, 24'd1, 8'h03, 1'b0, 24'd0, 24'd8380415);
    send(1'b1, 24'd100, 24'd200, 24'd300, 8'h04, 1'b0, 24'd60100, 24'd8320517);
    send(1'b1, 24'd8380416, 24'd8380416, 24'd8380416, 8'h05, 1'b0, 24'd0, 24'd8380415);
    send(1'b1, 24'd0, 24'd0, 24'd0, 8'h06, 1'b0, 24'd0, 24'd0);
    idle(8);

    // T3: back-to-back random vectors
    for (int i = 0; i < 512; i++) begin
      send_ref(DW'($urandom_range(0, Q - 1)), DW'($urandom_range(0, Q - 1)),
               DW'($urandom_range(0, Q - 1)), TW'($urandom_range(0, 255)));
    end
    idle(8);

    // T4: bubbles and a 3-cycle stall mid-stream
    for (int i = 0; i < 24; i++) begin
      if (i == 10) stall(3);
      if (i % 4 == 3) idle(1);
      else send_ref(DW'($urandom_range(0, Q - 1)), DW'($urandom_range(0, Q - 1)),
                    DW'($urandom_range(0, Q - 1)), TW'(i));
    end
    stall(2);
    idle(8);

    // T5: reset with 4 samples in flight
    for (int i = 0; i < 4; i++) send_ref(DW'(1000 + i), DW'(7), DW'(9), TW'(8'h40 + i));
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_u", bus.u, 0);
    chk("midrst_v", bus.v, 0);
    chk("midrst_out_tag", bus.out_tag, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1'b1, 24'd1, 24'd2, 24'd3, 8'h77, 1'b0, 24'd7, 24'd8380412);
    idle(8);

`ifdef BFLY_BYPASS_EN
    // T6: bypass interleaved with normal butterflies
    send(1'b1, 24'd5, 24'd9, 24'd123, 8'h90, 1'b1, 24'd5, 24'd9);
    send(1'b1, 24'd100, 24'd200, 24'd300, 8'h91, 1'b0, 24'd60100, 24'd8320517);
    send(1'b1, 24'd8380416, 24'd1, 24'd1, 8'h92, 1'b1, 24'd8380416, 24'd1);
    send(1'b1, 24'd1, 24'd2, 24'd3, 8'h93, 1'b0, 24'd7, 24'd8380412);
    idle(8);
`endif

    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
